// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// Holds the state encoding, the default widths and the bubble control value.
package pipe_pkg;

   localparam int DEF_DATA_W = 128;
   localparam int DEF_CTRL_W = 8;
   localparam int DEF_CNT_W  = 16;

   // The state value doubles as the occupancy output, so the encoding is fixed.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [DEF_CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter that updates on the falling edge and has an async active-low reset.
// Used for the stall and flush performance counters of pipe_stage_reg.
module pipe_sat_cnt
   import pipe_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: valid/ready handshake, 2-entry skid buffer, flush and bubble insertion.
// Optional stall/flush performance counters are enabled with the PIPE_STAGE_PERF_EN macro.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk_StageReg,
   input  logic              rst_n_StageReg,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   localparam logic [CTRL_W-1:0] C_BUBBLE = CTRL_W'(CTRL_BUBBLE);

   state_t            r_state;
   logic [DATA_W-1:0] r_mData;
   logic [CTRL_W-1:0] r_mCtrl;
   logic [DATA_W-1:0] r_sData;
   logic [CTRL_W-1:0] r_sCtrl;
   logic              w_acc;
   logic              w_drn;

   // Handshake flags come only from the state register, so ready never depends on out_ready.
   assign in_ready  = (r_state != ST_FULL);
   assign out_valid = (r_state != ST_EMPTY);
   assign w_acc     = in_valid & in_ready;
   assign w_drn     = out_valid & out_ready;

   always_ff @(negedge clk_StageReg or negedge rst_n_StageReg) begin
      if (!rst_n_StageReg) begin
         r_state <= ST_EMPTY;
         r_mData <= '0;
         r_mCtrl <= '0;
         r_sData <= '0;
         r_sCtrl <= '0;
      end else if (flush) begin
         r_state <= ST_EMPTY;
         r_mCtrl <= C_BUBBLE;
         r_sCtrl <= C_BUBBLE;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  r_state <= ST_ONE;
                  r_mData <= in_data;
                  r_mCtrl <= in_ctrl;
               end
            end
            ST_ONE: begin
               if (w_acc && w_drn) begin
                  r_mData <= in_data;
                  r_mCtrl <= in_ctrl;
               end else if (w_acc) begin
                  r_state <= ST_FULL;
                  r_sData <= in_data;
                  r_sCtrl <= in_ctrl;
               end else if (w_drn) begin
                  r_state <= ST_EMPTY;
                  r_mCtrl <= C_BUBBLE;
               end
            end
            ST_FULL: begin
               if (w_drn) begin
                  r_state <= ST_ONE;
                  r_mData <= r_sData;
                  r_mCtrl <= r_sCtrl;
                  r_sCtrl <= C_BUBBLE;
               end
            end
            default: begin
               r_state <= ST_EMPTY;
               r_mCtrl <= C_BUBBLE;
               r_sCtrl <= C_BUBBLE;
            end
         endcase
      end
   end

   assign out_data  = r_mData;
   assign out_ctrl  = r_mCtrl;
   assign occupancy = r_state;

`ifdef PIPE_STAGE_PERF_EN
   logic w_stallInc;
   logic w_flushInc;

   assign w_stallInc = in_valid & ~in_ready;
   assign w_flushInc = flush & (r_state != ST_EMPTY);

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_stallCnt (
      .i_clk   (clk_StageReg),
      .i_rst_n (rst_n_StageReg),
      .i_inc   (w_stallInc),
      .o_cnt   (stall_cnt)
   );

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_flushCnt (
      .i_clk   (clk_StageReg),
      .i_rst_n (rst_n_StageReg),
      .i_inc   (w_flushInc),
      .o_cnt   (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector bench for pipe_stage_reg; DUT updates on the falling edge, bench drives and samples on the rising edge.
// Counter checks are included when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

   localparam int DW = 16;
   localparam int CW = 8;
   localparam int NW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [NW-1:0] stall_cnt;
   logic [NW-1:0] flush_cnt;
`endif

   int nVec  = 0;
   int nMiss = 0;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk_StageReg   (clk),
      .rst_n_StageReg (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_ctrl        (in_ctrl),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_ctrl       (out_ctrl),
      .occupancy      (occupancy)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMiss++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      #2;
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_in_ready",  32'(in_ready),  32'h1);
      checkOutput("rst_occ",       32'(occupancy), 32'h0);
      checkOutput("rst_data",      32'(out_data),  32'h0);
      checkOutput("rst_ctrl",      32'(out_ctrl),  32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Streaming: one beat per cycle with out_ready held high
      applyStimulus(1'b1, 16'h11, 8'h01, 1'b1, 1'b0);
      tick();
      checkOutput("s1_valid", 32'(out_valid), 32'h1);
      checkOutput("s1_data",  32'(out_data),  32'h11);
      checkOutput("s1_occ",   32'(occupancy), 32'h1);
      applyStimulus(1'b1, 16'h22, 8'h02, 1'b1, 1'b0);
      tick();
      checkOutput("s2_data",  32'(out_data),  32'h22);
      checkOutput("s2_occ",   32'(occupancy), 32'h1);
      applyStimulus(1'b1, 16'h33, 8'h03, 1'b1, 1'b0);
      tick();
      checkOutput("s3_data",  32'(out_data),  32'h33);
      checkOutput("s3_ctrl",  32'(out_ctrl),  32'h03);
      applyStimulus(1'b1, 16'h44, 8'h04, 1'b1, 1'b0);
      tick();
      checkOutput("s4_data",  32'(out_data),  32'h44);
      checkOutput("s4_occ",   32'(occupancy), 32'h1);
      applyStimulus(1'b0, 16'h00, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("s_end_valid", 32'(out_valid), 32'h0);
      checkOutput("s_end_ctrl",  32'(out_ctrl),  32'h0);
      checkOutput("s_end_data",  32'(out_data),  32'h44);

      // Backpressure fills the skid entry
      applyStimulus(1'b1, 16'hA1, 8'h11, 1'b0, 1'b0);
      tick();
      checkOutput("bp1_data",  32'(out_data),  32'hA1);
      checkOutput("bp1_ready", 32'(in_ready),  32'h1);
      applyStimulus(1'b1, 16'hA2, 8'h12, 1'b0, 1'b0);
      tick();
      checkOutput("bp2_occ",   32'(occupancy), 32'h2);
      checkOutput("bp2_ready", 32'(in_ready),  32'h0);
      checkOutput("bp2_data",  32'(out_data),  32'hA1);
      applyStimulus(1'b0, 16'h00, 8'h00, 1'b0, 1'b0);
      tick();
      checkOutput("bp_hold_data", 32'(out_data), 32'hA1);
      checkOutput("bp_hold_ctrl", 32'(out_ctrl), 32'h11);
      applyStimulus(1'b0, 16'h00, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("bp3_data",  32'(out_data),  32'hA2);
      checkOutput("bp3_ctrl",  32'(out_ctrl),  32'h12);
      checkOutput("bp3_ready", 32'(in_ready),  32'h1);
      checkOutput("bp3_occ",   32'(occupancy), 32'h1);
      tick();
      checkOutput("bp4_occ",   32'(occupancy), 32'h0);

      // Bubble insertion after a lone beat drains
      applyStimulus(1'b1, 16'h05, 8'h5A, 1'b0, 1'b0);
      tick();
      checkOutput("bub1_ctrl", 32'(out_ctrl), 32'h5A);
      applyStimulus(1'b0, 16'h00, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("bub2_valid", 32'(out_valid), 32'h0);
      checkOutput("bub2_ctrl",  32'(out_ctrl),  32'h0);

      // Flush while FULL with a new beat offered
      applyStimulus(1'b1, 16'hC1, 8'h21, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'hC2, 8'h22, 1'b0, 1'b0);
      tick();
      checkOutput("fl_pre_occ", 32'(occupancy), 32'h2);
      applyStimulus(1'b1, 16'hBB, 8'h33, 1'b0, 1'b1);
      tick();
      checkOutput("fl_occ",   32'(occupancy), 32'h0);
      checkOutput("fl_valid", 32'(out_valid), 32'h0);
      checkOutput("fl_ctrl",  32'(out_ctrl),  32'h0);
      checkOutput("fl_data",  32'(out_data),  32'hC1);
`ifdef PIPE_STAGE_PERF_EN
      checkOutput("fl_flush_cnt", 32'(flush_cnt), 32'h1);
      checkOutput("fl_stall_cnt", 32'(stall_cnt), 32'h1);
`endif
      applyStimulus(1'b0, 16'h00, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("fl_post_valid", 32'(out_valid), 32'h0);
      checkOutput("fl_post_data",  32'(out_data),  32'hC1);

      // Asynchronous reset asserted between edges while FULL
      applyStimulus(1'b1, 16'hD1, 8'h31, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'hD2, 8'h32, 1'b0, 1'b0);
      tick();
      checkOutput("ar_pre_occ", 32'(occupancy), 32'h2);
      applyStimulus(1'b0, 16'h00, 8'h00, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_occ",   32'(occupancy), 32'h0);
      checkOutput("ar_valid", 32'(out_valid), 32'h0);
      checkOutput("ar_ready", 32'(in_ready),  32'h1);
      checkOutput("ar_data",  32'(out_data),  32'h0);
      checkOutput("ar_ctrl",  32'(out_ctrl),  32'h0);
`ifdef PIPE_STAGE_PERF_EN
      checkOutput("ar_flush_cnt", 32'(flush_cnt), 32'h0);
`endif
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("ar_rel_ready", 32'(in_ready),  32'h1);
      checkOutput("ar_rel_occ",   32'(occupancy), 32'h0);

`ifdef PIPE_STAGE_PERF_EN
      // Two accepts then eighteen stalled edges: counter must stop at 15
      applyStimulus(1'b1, 16'hE1, 8'h41, 1'b0, 1'b0);
      repeat (20) tick();
      checkOutput("perf_stall_sat", 32'(stall_cnt), 32'hF);
      checkOutput("perf_occ",       32'(occupancy), 32'h2);
`endif

      applyStimulus(1'b0, 16'h00, 8'h00, 1'b0, 1'b0);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One generic stage register with a valid/ready handshake, a 2-entry skid buffer so backpressure never forms a combinational path, synchronous flush, and automatic bubble insertion (control bits zeroed).
- Instantiated between any two pipeline stages; the payload is the concatenated datapath fields, and the control vector is the per-stage control bits (RegWrite, MemRW, Branch, etc.).

Parameters:
DATA_W, 128, width of datapath payload (PC, PC+4, ALU result, rs2, rd address, ...); value retained on bubble
CTRL_W, 8, width of control vector; forced to all-zero whenever the entry is invalid
CNT_W, 16, width of performance counters (used only with PIPE_STAGE_PERF_EN)

Ports:
clk_StageReg  in  1  clock; all state updates on the falling edge, matching the pipeline registers
rst_n_StageReg  in  1  reset; asynchronous assert, active-low
in_valid  in  1  upstream offers a beat
in_ready  out  1  stage can accept; decoded from state registers only
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
flush  in  1  synchronous kill of all held and incoming beats
out_valid  out  1  M entry valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  M payload
out_ctrl  out  CTRL_W  M control; all-zero when out_valid=0
occupancy  out  2  number of held entries: 0, 1 or 2
stall_cnt  out  CNT_W  only with PIPE_STAGE_PERF_EN
flush_cnt  out  CNT_W  only with PIPE_STAGE_PERF_EN

Behaviour:
- Storage: main entry M drives the outputs; skid entry S. State encoding: EMPTY=0, ONE=1, FULL=2. occupancy equals the state.
- Definitions: acc = in_valid & in_ready; drn = out_valid & out_ready.
- Reset (async, rst_n_StageReg=0):
  - state=EMPTY; M and S data and ctrl = 0; counters = 0.
  - out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- in_ready = (state != FULL). It has no combinational dependence on out_ready or in_valid.
- out_valid = (state != EMPTY).
- Transitions, evaluated on the falling edge when flush=0:
  - EMPTY: acc -> ONE, M<=in.
  - ONE: acc&drn -> ONE, M<=in. acc&!drn -> FULL, S<=in. !acc&drn -> EMPTY, M.ctrl<=0. Otherwise hold.
  - FULL: drn -> ONE, M<=S, S.ctrl<=0. Otherwise hold. No accept is possible because in_ready=0.
- Flush (flush=1 at the edge) has highest priority over acc and drn:
  - state->EMPTY; M.ctrl and S.ctrl <=0; data fields hold their old values.
  - Any beat offered in the same cycle is discarded, even if in_ready=1.
  - A drn in the same cycle still counts as delivered downstream.
- Latency: accept-to-out_valid is 1 edge. Throughput is 1 beat/cycle sustained when out_ready=1. Order is strictly FIFO.
- Reset deasserted mid-operation: behaves as from EMPTY. There is no partial state.
- Holding with out_valid=1 and out_ready=0 keeps out_data and out_ctrl stable.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined:
  - stall_cnt increments on each edge where in_valid=1 and in_ready=0.
  - flush_cnt increments on each edge where flush=1 and occupancy!=0.
  - Both saturate at 2^CNT_W-1 and reset to 0.
- Undefined: stall_cnt and flush_cnt ports and their logic are absent. Core behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - state localparams ST_EMPTY/ST_ONE/ST_FULL, 2-bit state type;
  - default DATA_W/CTRL_W/CNT_W constants;
  - CTRL_BUBBLE constant (all-zero).
- Sub-module pipe_sat_cnt (CNT_W saturating counter with inc and async active-low reset). It is instantiated twice only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset then stream: in_valid=1 for 4 beats, data 0x11..0x44, out_ready=1 -> out_valid on the next edge after each accept, outputs 0x11,0x22,0x33,0x44 back-to-back, occupancy stays 1.
- Backpressure: out_ready=0 while beats 0xA1,0xA2 are sent -> occupancy 2, in_ready=0, out_data=0xA1 held. Then out_ready=1 -> 0xA1 then 0xA2, in_ready=1 after the first drain.
- Bubble: single beat ctrl=0x5A drained, no new input -> out_valid=0, out_ctrl=0x00.
- Flush in FULL with in_valid=1 (data 0xBB) -> next edge occupancy=0, out_ctrl=0, 0xBB never appears. With the macro: flush_cnt=1.
- Async reset mid-FULL: drop rst_n_StageReg between edges -> outputs go to reset values immediately, without waiting for the clock. Release -> in_ready=1, occupancy=0.
- Perf (macro, CNT_W=4): hold in_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
